// File: rtl/upconverter_if.sv
// Baseband I/Q, NCO controls and real DAC-side output of the upconverter.
// Master drives the baseband/controls; slave is the upconverter itself.
interface upconverter_if;
    logic signed [15:0] in_i;
    logic signed [15:0] in_q;
    logic        [25:0] lo_freq;
    logic               lo_ns_en;
    logic               iq_swap;
    logic signed [15:0] out;
    logic               out_valid;

    modport master (
        output in_i, in_q, lo_freq, lo_ns_en, iq_swap,
        input  out, out_valid
    );

    modport slave (
        input  in_i, in_q, lo_freq, lo_ns_en, iq_swap,
        output out, out_valid
    );
endinterface

// File: rtl/upconverter.sv
// Quadrature upconverter: out = I*cos(phs) - Q*sin(phs), noise-shaped 26-bit NCO, quarter-wave ROM.
// Latency 5 clocks from input sample to out; no backpressure, one sample accepted and produced every clock.
module upconverter (
    input  logic          clk,
    input  logic          reset,
    upconverter_if.slave  bus
);
    localparam int  DSZ     = 16;
    localparam int  FSZ     = 26;
    localparam int  PSZ     = 12;
    localparam int  LATENCY = 5;
    localparam real PI      = 3.14159265358979323846;

    // Quarter-wave sine magnitude table, k = 0..1024 covers 0..pi/2 inclusive.
    logic [14:0] rom [0:1024];
    for (genvar k = 0; k <= 1024; k++) begin : g_rom
        localparam int V = $rtoi(32767.0 * $sin(2.0 * PI * k / 4096.0) + 0.5);
        assign rom[k] = 15'(V);
    end

    logic [FSZ-1:0] acc, ns_acc, ns_fb;
    logic [PSZ-1:0] phs;

    logic signed [DSZ-1:0] i_r, q_r, i1, q1, i2, q2, sin_s, cos_s;
    logic        [PSZ-1:0] ph_r;
    logic            [1:0] quad1;
    logic           [14:0] sin_m, cos_m;
    logic signed   [31:0] p_i, p_q;
    logic signed   [32:0] s_r;
    logic signed [DSZ-1:0] out_r;
    logic            [2:0] cnt;

    logic           [10:0] idx, idx_sin, idx_cos;
    logic signed   [33:0] rnd;
    logic signed   [18:0] shr;
    logic signed [DSZ-1:0] sat;

    assign phs   = ns_acc[FSZ-1:FSZ-PSZ];
    assign ns_fb = bus.lo_ns_en ? {{(FSZ-14){ns_acc[13]}}, ns_acc[13:0]} : '0;

    // Odd quadrants run the table backwards for sin; cos always takes the complement.
    always_comb begin
        idx     = {1'b0, ph_r[9:0]};
        idx_sin = ph_r[10] ? 11'd1024 - idx : idx;
        idx_cos = ph_r[10] ? idx : 11'd1024 - idx;
    end

    always_comb begin
        rnd = {s_r[32], s_r} + 34'sd16384;
        shr = 19'(rnd >>> 15);
        if (shr > 19'sd32767)
            sat = 16'sh7fff;
        else if (shr < -19'sd32768)
            sat = 16'sh8000;
        else
            sat = shr[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            ns_acc <= '0;
            i_r    <= '0;
            q_r    <= '0;
            ph_r   <= '0;
            i1     <= '0;
            q1     <= '0;
            quad1  <= '0;
            sin_m  <= '0;
            cos_m  <= '0;
            i2     <= '0;
            q2     <= '0;
            sin_s  <= '0;
            cos_s  <= '0;
            p_i    <= '0;
            p_q    <= '0;
            s_r    <= '0;
            out_r  <= '0;
            cnt    <= '0;
        end else begin
            acc    <= acc + bus.lo_freq;
            ns_acc <= acc + ns_fb;

            i_r  <= bus.iq_swap ? bus.in_q : bus.in_i;
            q_r  <= bus.iq_swap ? bus.in_i : bus.in_q;
            ph_r <= phs;

            i1    <= i_r;
            q1    <= q_r;
            quad1 <= ph_r[11:10];
            sin_m <= rom[idx_sin];
            cos_m <= rom[idx_cos];

            i2    <= i1;
            q2    <= q1;
            sin_s <= quad1[1]            ? -$signed({1'b0, sin_m}) : $signed({1'b0, sin_m});
            cos_s <= (quad1[1]^quad1[0]) ? -$signed({1'b0, cos_m}) : $signed({1'b0, cos_m});

            p_i <= i2 * cos_s;
            p_q <= q2 * sin_s;

            s_r   <= $signed({p_i[31], p_i}) - $signed({p_q[31], p_q});
            out_r <= sat;

            if (cnt != 3'(LATENCY + 1))
                cnt <= cnt + 3'd1;
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = (cnt == 3'(LATENCY + 1));
endmodule

// File: tb/tb_upconverter.sv
// Bench for upconverter: math-level model of NCO phase and mixed output, 5-deep expected-value queue.
module tb_upconverter;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic reset;

    upconverter_if bus();

    upconverter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned m_acc, m_ns;
    int          m_q[$];
    int          m_edges;
    int          last_phs;
    longint      ph_sum;
    longint      sum_off, sum_on;
    int          cap [8];

    // Signed sine at phase p of a 4096-point circle, rounded to 15-bit magnitude.
    function automatic int sin_tab(int p);
        int  m;
        int  mag;
        real x;
        m = p % 2048;
        if (m > 1024) m = 2048 - m;
        x   = 32767.0 * $sin(2.0 * PI * m / 4096.0);
        mag = $rtoi(x + 0.5);
        return (p >= 2048) ? -mag : mag;
    endfunction

    function automatic int expect_out(int iv, int qv, int p);
        longint s, t;
        s = longint'(iv) * sin_tab((p + 1024) % 4096) - longint'(qv) * sin_tab(p);
        t = (s + 16384) >>> 15;
        if (t > 32767)  t = 32767;
        if (t < -32768) t = -32768;
        return int'(t);
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: advance the model on the pre-edge inputs, then compare the DUT just after the edge.
    task automatic step();
        int iv, qv, e, exp_out;
        if (reset) begin
            m_acc   = 0;
            m_ns    = 0;
            m_q     = {0, 0, 0, 0, 0};
            m_edges = 0;
        end else begin
            last_phs = int'(m_ns >> 14);
            ph_sum  += last_phs;
            iv = bus.iq_swap ? int'(bus.in_q) : int'(bus.in_i);
            qv = bus.iq_swap ? int'(bus.in_i) : int'(bus.in_q);
            m_q.push_back(expect_out(iv, qv, last_phs));
            e = int'(m_ns & 32'h3fff);
            if (e >= 8192) e -= 16384;
            if (!bus.lo_ns_en) e = 0;
            m_ns  = (m_acc + e) & 32'h3ffffff;
            m_acc = (m_acc + bus.lo_freq) & 32'h3ffffff;
            m_edges++;
        end
        @(posedge clk);
        #1;
        exp_out = reset ? 0 : m_q.pop_front();
        check("out", bus.out, exp_out);
        check("out_valid", bus.out_valid, (m_edges >= 6) ? 1 : 0);
    endtask

    task automatic capture(int n);
        for (int i = 0; i < n; i++) begin
            step();
            cap[i] = bus.out;
        end
    endtask

    function automatic bit is_rot(int a, int b, int c, int d);
        int pat [4];
        bit ok;
        pat = '{a, b, c, d};
        for (int r = 0; r < 4; r++) begin
            ok = 1'b1;
            for (int i = 0; i < 4; i++)
                if (cap[i] != pat[(i + r) % 4]) ok = 1'b0;
            if (ok) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        int mx, mn;
        longint d;

        reset        = 1'b1;
        bus.in_i     = 16'sd16384;
        bus.in_q     = 16'sd0;
        bus.lo_freq  = 26'd0;
        bus.lo_ns_en = 1'b0;
        bus.iq_swap  = 1'b0;
        repeat (3) step();
        check("rst_out", bus.out, 0);
        check("rst_valid", bus.out_valid, 0);

        // Fill with a DC phase: valid after exactly 6 edges, then I scaled by 32767/32768.
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("fill_valid", bus.out_valid, (k >= 6) ? 1 : 0);
        end
        for (int k = 0; k < 4; k++) begin
            check("dc_out", bus.out, 16384);
            step();
        end

        // fclk/4 tone.
        bus.lo_freq = 26'h1000000;
        repeat (8) step();
        capture(4);
        check("fs4_i", is_rot(16384, 0, -16383, 0), 1);

        bus.iq_swap = 1'b1;
        repeat (6) step();
        capture(4);
        check("fs4_swap", is_rot(0, -16383, 0, 16384), 1);

        bus.iq_swap = 1'b0;
        bus.in_i    = 16'sd0;
        bus.in_q    = 16'sd16384;
        repeat (6) step();
        capture(4);
        check("fs4_q", is_rot(0, -16383, 0, 16384), 1);

        // Saturation at both extremes.
        bus.lo_freq = 26'h0800000;
        bus.in_i    = 16'sd32767;
        bus.in_q    = -16'sd32768;
        repeat (6) step();
        capture(8);
        mx = cap[0];
        mn = cap[0];
        for (int i = 1; i < 8; i++) begin
            if (cap[i] > mx) mx = cap[i];
            if (cap[i] < mn) mn = cap[i];
        end
        check("sat_max", mx, 32767);
        check("sat_min", mn, -32768);

        // Mid-stream reset held 3 cycles.
        bus.lo_freq = 26'h1000000;
        bus.in_i    = 16'sd16384;
        bus.in_q    = 16'sd0;
        repeat (4) step();
        reset = 1'b1;
        step();
        check("mid_rst_out", bus.out, 0);
        check("mid_rst_valid", bus.out_valid, 0);
        repeat (2) step();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("refill_valid", bus.out_valid, (k >= 6) ? 1 : 0);
        end

        // Noise shaping off vs on at lo_freq = 0x2000.
        reset       = 1'b1;
        bus.lo_freq = 26'h2000;
        bus.lo_ns_en = 1'b0;
        step();
        reset  = 1'b0;
        ph_sum = 0;
        for (int k = 1; k <= 8192; k++) begin
            step();
            if (k == 100) check("ns_off_phs100", last_phs, 49);
            if (k == 103) check("ns_off_phs103", last_phs, 50);
        end
        sum_off = ph_sum;

        reset        = 1'b1;
        bus.lo_ns_en = 1'b1;
        step();
        reset  = 1'b0;
        ph_sum = 0;
        for (int k = 1; k <= 8192; k++) begin
            step();
            if (k == 5) check("ns_on_phs5", last_phs, 1);
            if (k == 8) check("ns_on_phs8", last_phs, 2);
        end
        sum_on = ph_sum;
        d = sum_on - sum_off;
        if (d < 0) d = -d;
        check("ns_mean", (d <= 8192) ? 1 : 0, 1);

        // Per-cycle changing inputs and controls.
        for (int k = 0; k < 200; k++) begin
            bus.in_i     = 16'($urandom);
            bus.in_q     = 16'($urandom);
            bus.iq_swap  = k[2];
            bus.lo_ns_en = k[3];
            if (k % 16 == 0) bus.lo_freq = 26'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/upconverter.md
Name: upconverter

Overview:
Digital quadrature upconverter, the transmit-side counterpart of the receive tuner. It takes a complex baseband I/Q stream and mixes it with an on-chip NCO to produce one real output sample per clock: out = I·cos(φ) − Q·sin(φ). The NCO uses the same 26-bit tuning word, 12-bit phase and residue noise-shaping scheme as the tuner, so the same lo_freq value places TX and RX on the same frequency. It feeds the DAC path.

Parameters:
DSZ, 16, data word size (I, Q, out); fixed localparam
FSZ, 26, NCO accumulator/tuning word size; fixed localparam
PSZ, 12, phase word size; fixed localparam
LATENCY, 5, clocks from input sample to out; fixed localparam

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_i  input  16  signed in-phase baseband, sampled every clock
in_q  input  16  signed quadrature baseband, sampled every clock
lo_freq  input  26  NCO tuning word; f = lo_freq·fclk/2^26
lo_ns_en  input  1  NCO phase noise-shaping enable
iq_swap  input  1  swap roles of in_i and in_q
out  output  16  signed real upconverted sample
out_valid  output  1  high once the pipeline holds valid data

Behaviour:
- Reset (synchronous, active-high): acc, ns_acc, all pipeline registers, out and the fill counter clear to 0; out=0 and out_valid=0 from the first edge with reset high. Reset mid-operation discards all in-flight samples.
- NCO: acc <= acc + lo_freq, modulo 2^26. ns_acc <= acc + (lo_ns_en ? sign-extended ns_acc[13:0] : 0), modulo 2^26. phs = ns_acc[25:14].
- Pipeline, inputs sampled at edge n:
  - E n: iq_swap=0 gives i_r=in_i, q_r=in_q; iq_swap=1 gives i_r=in_q, q_r=in_i. ph_r <= phs.
  - E n+1: quarter-wave ROM lookups for cos and sin magnitudes. ROM: 1025 entries, k=0..1024, value round(32767·sin(2πk/4096)), unsigned 15-bit. Quadrant = ph_r[11:10], index = ph_r[9:0]. sin uses index, or 1024−index in odd quadrants. cos uses the complementary index.
  - E n+2: sign applied. sin is negative in quadrants 2–3; cos is negative in quadrants 1–2. Result is signed 16-bit.
  - E n+3: p_i = i·cos and p_q = q·sin, each signed 32-bit.
  - E n+4: s = p_i − p_q, signed 33-bit.
  - E n+5: out = saturate16((s + 2^14) >>> 15). Arithmetic shift. Clamp to [−32768, 32767].
- Data and phase stay aligned: out after edge n+5 uses the inputs and phs that were sampled at edge n.
- out_valid: a 3-bit counter increments on each edge with reset low, saturating at LATENCY+1. out_valid=1 when count = LATENCY+1, i.e. after the 6th edge following reset release. It then stays 1 until reset.
- lo_freq, lo_ns_en and iq_swap may change on any cycle and take effect at the next edge. There is no glitch handling beyond that.
- lo_freq=0 with lo_ns_en=0 gives constant phs=0, so out = I scaled by 32767/32768.

Test Plan:
- Reset release with lo_freq=0, in_i=16384, in_q=0 -> out_valid low for 5 edges, rises after the 6th edge. out=16384 thereafter.
- lo_freq=2^24 (fclk/4), ns off, in_i=16384, in_q=0 -> out repeats 16384, 0, −16383, 0 at 5-cycle latency. iq_swap=1 with the same stimulus -> 0, −16383, 0, 16384.
- lo_freq=2^24, in_i=0, in_q=16384 -> out repeats 0, −16383, 0, 16384. This confirms the −Q·sin sign.
- Saturation: lo_freq=2^23, in_i=32767, in_q=−32768 -> out=32767 at phs=512 (cos=sin=23170) and out=−32768 at phs=2560. No wrap at either point.
- Noise shaping: lo_freq=0x2000, compare ns off and ns on over 8192 cycles -> ns off: phs steps by 1 every 2 cycles. ns on: phs sequence matches the bit-accurate model, and the phs mean matches ns off within 1 LSB.
- Reset asserted mid-stream, then released after 3 cycles -> out=0 and out_valid=0 on the first reset edge. acc restarts from 0. out_valid rises again after 6 edges.
